// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and sizing constants for the serial bus arbiter
package bus_pkg;
  localparam int SEL_W = 2;
  localparam int NUM_MASTERS = 2;
  localparam int TIMEOUT = 16;
  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    ADDR,
    SLAVE_WAIT,
    CONNECT
  } state_t;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: two-requester round-robin picker; on a tie the requester that was not last wins
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] pick
);
  assign pick[0] = req[0] & (~req[1] | last);
  assign pick[1] = req[1] & (~req[0] | ~last);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin serial bus arbiter with slave-select decode and wait timeout
module bus_arbiter #(
  parameter int NUM_SLAVES = 3,
  parameter int TIMEOUT = bus_pkg::TIMEOUT
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            bus_req_m,
  input  logic [1:0]            addr_tx_m,
  input  logic [1:0]            data_tx_m,
  input  logic [1:0]            valid_s_m,
  input  logic [1:0]            write_en_m,
  output logic [1:0]            bus_ready_m,
  output logic [1:0]            data_rx_m,
  output logic [1:0]            slave_valid_m,
  output logic                  addr_s,
  output logic                  data_s,
  output logic                  write_en_s,
  output logic [NUM_SLAVES-1:0] valid_s,
  input  logic [NUM_SLAVES-1:0] slave_ready,
  input  logic [NUM_SLAVES-1:0] slave_valid,
  input  logic [NUM_SLAVES-1:0] data_rx_s,
  output logic [1:0]            grant,
  output logic                  timeout_err
);
  import bus_pkg::*;
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int BW = SEL_W > 1 ? $clog2(SEL_W) : 1;
  state_t state;
  logic [SEL_W-1:0] sel;
  logic [BW-1:0] bit_cnt;
  logic [CW-1:0] wait_cnt;
  logic last_grant;
  logic [1:0] pick;
  logic [NUM_SLAVES-1:0] sel_oh;
  logic own, conn, ready_sel;

  rr_pick2 u_pick (
    .req(bus_req_m),
    .last(last_grant),
    .pick(pick)
  );

  // Out-of-range selects decode to an all-zero one-hot, so they can never look ready
  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
    assign sel_oh[i] = sel == SEL_W'(i);
  end

  assign own = grant[1];
  assign conn = state == CONNECT;
  assign ready_sel = |(slave_ready & sel_oh);
  assign addr_s = conn & addr_tx_m[own];
  assign data_s = conn & data_tx_m[own];
  assign write_en_s = conn & write_en_m[own];
  assign valid_s = (conn & valid_s_m[own]) ? sel_oh : '0;
  assign data_rx_m = (conn & |(data_rx_s & sel_oh)) ? grant : 2'b00;
  assign slave_valid_m = (conn & |(slave_valid & sel_oh)) ? grant : 2'b00;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= '0;
      bus_ready_m <= '0;
      timeout_err <= 1'b0;
      sel <= '0;
      bit_cnt <= '0;
      wait_cnt <= '0;
      last_grant <= 1'b1;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (|bus_req_m) begin
          grant <= pick;
          bus_ready_m <= pick;
          state <= GRANT;
        end
        GRANT: if (!bus_req_m[own]) begin
          grant <= '0;
          bus_ready_m <= '0;
          state <= IDLE;
        end else if (valid_s_m[own]) begin
          bus_ready_m <= '0;
          bit_cnt <= '0;
          state <= ADDR;
        end
        ADDR: if (valid_s_m[own]) begin
          sel <= {sel[SEL_W-2:0], addr_tx_m[own]};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == BW'(SEL_W-1)) begin
            wait_cnt <= '0;
            state <= SLAVE_WAIT;
          end
        end
        SLAVE_WAIT: if (ready_sel) begin
          bus_ready_m <= grant;
          state <= CONNECT;
        end else if (wait_cnt == CW'(TIMEOUT-1)) begin
          timeout_err <= 1'b1;
          last_grant <= own;
          grant <= '0;
          state <= IDLE;
        end else begin
          wait_cnt <= &wait_cnt ? wait_cnt : wait_cnt + 1'b1;
        end
        CONNECT: if (!bus_req_m[own]) begin
          last_grant <= own;
          grant <= '0;
          bus_ready_m <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table plus scoreboarded sequences for arbitration, routing, timeout and reset
module tb_bus_arbiter;
  localparam int GR = 0, BR = 1, VS = 2, DS = 3, RX = 4, SV = 5, TO = 6, AS = 7, WE = 8;

  logic clock = 1'b0;
  logic reset;
  logic [1:0] bus_req_m, addr_tx_m, data_tx_m, valid_s_m, write_en_m;
  logic [1:0] bus_ready_m, data_rx_m, slave_valid_m, grant;
  logic addr_s, data_s, write_en_s, timeout_err;
  logic [2:0] valid_s, slave_ready, slave_valid, data_rx_s;

  bus_arbiter #(.NUM_SLAVES(3), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .bus_req_m(bus_req_m), .addr_tx_m(addr_tx_m),
    .data_tx_m(data_tx_m), .valid_s_m(valid_s_m), .write_en_m(write_en_m),
    .bus_ready_m(bus_ready_m), .data_rx_m(data_rx_m), .slave_valid_m(slave_valid_m),
    .addr_s(addr_s), .data_s(data_s), .write_en_s(write_en_s), .valid_s(valid_s),
    .slave_ready(slave_ready), .slave_valid(slave_valid), .data_rx_s(data_rx_s),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    string name;
    int sig;
    logic [7:0] e;
  } scb_t;

  typedef struct {
    logic [1:0] addr, data, valid, wen;
    logic [2:0] rx, sv;
    logic e_addr, e_data, e_wen;
    logic [2:0] e_valid;
    logic [1:0] e_rx, e_sv;
  } vec_t;

  scb_t sb[$];
  scb_t it;
  int checks = 0;
  int errors = 0;

  function automatic logic [7:0] act(input int s);
    case (s)
      GR: return 8'(grant);
      BR: return 8'(bus_ready_m);
      VS: return 8'(valid_s);
      DS: return 8'(data_s);
      RX: return 8'(data_rx_m);
      SV: return 8'(slave_valid_m);
      TO: return 8'(timeout_err);
      AS: return 8'(addr_s);
      default: return 8'(write_en_s);
    endcase
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      it = sb.pop_front();
      checks++;
      if (act(it.sig) !== it.e) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h at %0t", it.name, act(it.sig), it.e, $time);
      end
    end
  end

  task automatic exp(input string n, input int s, input logic [7:0] e);
    sb.push_back('{n, s, e});
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called in the owner's GRANT cycle; returns in the first SLAVE_WAIT cycle
  task automatic send_prefix(input int m, input logic [1:0] p);
    exp("grant_ready", BR, (m == 1) ? 8'd2 : 8'd1);
    valid_s_m[m] = 1'b1;
    addr_tx_m[m] = 1'b0;
    step();
    exp("addr_ready_low", BR, 8'd0);
    addr_tx_m[m] = p[1];
    step();
    addr_tx_m[m] = p[0];
    step();
    valid_s_m[m] = 1'b0;
    addr_tx_m[m] = 1'b0;
  endtask

  initial begin
    vec_t vt[6];
    logic [7:0] pay;
    vt[0] = '{2'b01, 2'b00, 2'b00, 2'b00, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
    vt[1] = '{2'b10, 2'b10, 2'b10, 2'b10, 3'b101, 3'b101, 1'b0, 1'b0, 1'b0, 3'b000, 2'b00, 2'b00};
    vt[2] = '{2'b00, 2'b01, 2'b01, 2'b01, 3'b010, 3'b010, 1'b0, 1'b1, 1'b1, 3'b010, 2'b01, 2'b01};
    vt[3] = '{2'b11, 2'b11, 2'b11, 2'b11, 3'b111, 3'b111, 1'b1, 1'b1, 1'b1, 3'b010, 2'b01, 2'b01};
    vt[4] = '{2'b00, 2'b01, 2'b01, 2'b00, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 3'b010, 2'b01, 2'b00};
    vt[5] = '{2'b01, 2'b00, 2'b00, 2'b01, 3'b000, 3'b010, 1'b1, 1'b0, 1'b1, 3'b000, 2'b00, 2'b01};
    reset = 1'b1;
    {bus_req_m, addr_tx_m, data_tx_m, valid_s_m, write_en_m} = '0;
    {slave_ready, slave_valid, data_rx_s} = '0;
    exp("rst_grant", GR, 0); exp("rst_ready", BR, 0); exp("rst_timeout", TO, 0); exp("rst_valid_s", VS, 0);
    step();
    step();
    // single master 0, prefix 01 to ready slave 1
    reset = 1'b0;
    slave_ready = 3'b010;
    bus_req_m = 2'b01;
    exp("t1_idle_grant", GR, 0); exp("t1_idle_ready", BR, 0);
    step();
    exp("t1_grant", GR, 1);
    send_prefix(0, 2'b01);
    exp("t1_wait_ready", BR, 0); exp("t1_wait_valid_s", VS, 0);
    step();
    exp("t1_conn_ready", BR, 1); exp("t1_conn_grant", GR, 1);
    for (int i = 0; i < 6; i++) begin
      addr_tx_m = vt[i].addr; data_tx_m = vt[i].data; valid_s_m = vt[i].valid; write_en_m = vt[i].wen;
      data_rx_s = vt[i].rx; slave_valid = vt[i].sv;
      exp($sformatf("vec%0d_addr_s", i), AS, 8'(vt[i].e_addr));
      exp($sformatf("vec%0d_data_s", i), DS, 8'(vt[i].e_data));
      exp($sformatf("vec%0d_write_en_s", i), WE, 8'(vt[i].e_wen));
      exp($sformatf("vec%0d_valid_s", i), VS, 8'(vt[i].e_valid));
      exp($sformatf("vec%0d_data_rx_m", i), RX, 8'(vt[i].e_rx));
      exp($sformatf("vec%0d_slave_valid_m", i), SV, 8'(vt[i].e_sv));
      step();
    end
    {addr_tx_m, data_tx_m, valid_s_m, write_en_m, data_rx_s, slave_valid} = '0;
    pay = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      data_tx_m = {1'b0, pay[i]};
      valid_s_m = 2'b01;
      exp($sformatf("pay_bit%0d", i), DS, 8'(pay[i]));
      exp($sformatf("pay_valid%0d", i), VS, 8'h02);
      step();
    end
    {data_tx_m, valid_s_m} = '0;
    bus_req_m = 2'b00;
    exp("t1_release_cycle_ready", BR, 1);
    step();
    exp("t1_released_grant", GR, 0); exp("t1_released_ready", BR, 0);
    step();
    // both masters from reset; master 0 reads 0x3C from slave 0
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus_req_m = 2'b11;
    slave_ready = 3'b001;
    step();
    exp("t2_tie_grant", GR, 1);
    send_prefix(0, 2'b00);
    exp("t2_wait_ready", BR, 0);
    step();
    pay = 8'h3C;
    for (int i = 7; i >= 0; i--) begin
      data_rx_s = {~pay[i], ~pay[i], pay[i]};
      slave_valid = 3'b111;
      exp($sformatf("rd_bit%0d", i), RX, {7'd0, pay[i]});
      exp($sformatf("rd_sv%0d", i), SV, 8'h01);
      exp($sformatf("rd_hold_grant%0d", i), GR, 8'h01);
      step();
    end
    {data_rx_s, slave_valid} = '0;
    bus_req_m = 2'b10;
    exp("t2_release_ready", BR, 1);
    step();
    exp("t2_gap_grant", GR, 0); exp("t2_gap_ready", BR, 0);
    step();
    exp("t2_m1_grant", GR, 2); exp("t2_m1_ready", BR, 2);
    // master 1 prefix 10, slave 2 not ready for 5 cycles
    slave_ready = 3'b000;
    send_prefix(1, 2'b10);
    for (int i = 0; i < 5; i++) begin
      exp($sformatf("t3_wait%0d_ready", i), BR, 0);
      step();
    end
    slave_ready = 3'b100;
    exp("t3_ready_edge_ready", BR, 0);
    step();
    valid_s_m = 2'b10;
    exp("t3_conn_ready", BR, 2); exp("t3_conn_grant", GR, 2); exp("t3_conn_valid_s", VS, 8'h04);
    step();
    valid_s_m = 2'b00;
    bus_req_m = 2'b00;
    step();
    // invalid prefix 11 with master 1 waiting
    slave_ready = 3'b111;
    bus_req_m = 2'b11;
    exp("t4_idle_grant", GR, 0);
    step();
    exp("t4_grant_m0", GR, 1);
    send_prefix(0, 2'b11);
    for (int i = 0; i < 16; i++) begin
      exp($sformatf("t4_wait%0d_ready", i), BR, 0);
      exp($sformatf("t4_wait%0d_timeout", i), TO, 0);
      step();
    end
    exp("t4_timeout_pulse", TO, 1); exp("t4_abort_grant", GR, 0); exp("t4_abort_ready", BR, 0);
    step();
    exp("t4_timeout_single", TO, 0); exp("t4_next_grant", GR, 2); exp("t4_next_ready", BR, 2);
    // master 1 to slave 1, reset mid-payload
    send_prefix(1, 2'b01);
    exp("t6_wait_ready", BR, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      data_tx_m = {i[0] ? 1'b0 : 1'b1, 1'b0};
      valid_s_m = 2'b10;
      exp($sformatf("t6_pay%0d", i), DS, i[0] ? 8'd0 : 8'd1);
      exp($sformatf("t6_valid_s%0d", i), VS, 8'h02);
      exp($sformatf("t6_ready%0d", i), BR, 8'h02);
      step();
    end
    {addr_tx_m, data_tx_m, valid_s_m, write_en_m} = 8'b10101010;
    slave_valid = 3'b111;
    data_rx_s = 3'b111;
    reset = 1'b1;
    exp("rst_mid_grant", GR, 0); exp("rst_mid_ready", BR, 0); exp("rst_mid_valid_s", VS, 0);
    exp("rst_mid_data_s", DS, 0); exp("rst_mid_addr_s", AS, 0); exp("rst_mid_wen", WE, 0);
    exp("rst_mid_rx", RX, 0); exp("rst_mid_sv", SV, 0); exp("rst_mid_timeout", TO, 0);
    step();
    {addr_tx_m, data_tx_m, valid_s_m, write_en_m, slave_valid, data_rx_s} = '0;
    bus_req_m = 2'b11;
    reset = 1'b0;
    exp("t6_idle_grant", GR, 0);
    step();
    exp("t6_tie_grant", GR, 1); exp("t6_tie_ready", BR, 1); exp("t6_no_err", TO, 0);
    step();
    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
